// File: rtl/mfcc_frame_buffer.sv
// Double-buffered frame store between the MFCC pipeline and a ready/valid
// consumer. The producer cannot be stalled, so a frame that finds its target
// bank still occupied is discarded whole and counted.
module mfcc_frame_buffer #(
    parameter int DATA_W     = 32,
    parameter int MAX_COEFFS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mfcc_in,
    input  logic              mfcc_in_valid,
    input  logic [7:0]        num_mfcc_coeffs,
    output logic [DATA_W-1:0] feat_data,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic              feat_last,
    output logic [7:0]        feat_index,
    output logic [7:0]        frames_dropped,
    output logic              overflow,
    input  logic              clr_overflow
);
    localparam int AW = (MAX_COEFFS > 1) ? $clog2(MAX_COEFFS) : 1;

    typedef enum logic {W_FILL, W_DROP} wr_state_t;
    typedef enum logic {R_IDLE, R_SEND} rd_state_t;

    // Bank storage and per-bank frame length (stored as L-1); not reset,
    // the full flags gate every use.
    logic [DATA_W-1:0] mem      [2][MAX_COEFFS];
    logic [7:0]        last_idx [2];
    logic [1:0]        full;

    wr_state_t wr_state, wr_state_n;
    logic      wr_bank;
    logic [7:0] wr_idx, cur_last;

    rd_state_t rd_state, rd_state_n;
    logic      rd_bank;

    logic       frame_start, drop_start, wr_store, wr_done, wr_is_last;
    logic [7:0] new_last, eff_last, next_idx;
    logic       rd_start, rd_xfer, rd_done;

    // Writer/reader strobes and next-state logic
    always_comb begin
        wr_state_n  = wr_state;
        rd_state_n  = rd_state;
        frame_start = mfcc_in_valid && (wr_state == W_FILL) && (wr_idx == 8'd0);
        if (num_mfcc_coeffs == 8'd0 || {1'b0, num_mfcc_coeffs} > 9'(MAX_COEFFS))
            new_last = 8'(MAX_COEFFS - 1);
        else
            new_last = num_mfcc_coeffs - 8'd1;
        eff_last   = frame_start ? new_last : cur_last;
        wr_is_last = (wr_idx == eff_last);
        // Registered flag only: a bank freed this same edge still counts as full.
        drop_start = frame_start && full[wr_bank];
        wr_store   = mfcc_in_valid && (wr_state == W_FILL) && !drop_start;
        wr_done    = wr_store && wr_is_last;
        if (mfcc_in_valid) begin
            case (wr_state)
                W_FILL:  if (drop_start && !wr_is_last) wr_state_n = W_DROP;
                W_DROP:  if (wr_is_last) wr_state_n = W_FILL;
                default: wr_state_n = W_FILL;
            endcase
        end

        rd_start = (rd_state == R_IDLE) && full[rd_bank];
        rd_xfer  = (rd_state == R_SEND) && feat_ready;
        rd_done  = rd_xfer && feat_last;
        next_idx = feat_index + 8'd1;
        if (rd_start)     rd_state_n = R_SEND;
        else if (rd_done) rd_state_n = R_IDLE;
    end

    // Writer state, bank pointer, word index and latched frame length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_FILL;
            wr_bank  <= 1'b0;
            wr_idx   <= 8'd0;
            cur_last <= 8'd0;
        end else begin
            wr_state <= wr_state_n;
            if (frame_start)   cur_last <= new_last;
            if (mfcc_in_valid) wr_idx   <= wr_is_last ? 8'd0 : wr_idx + 8'd1;
            if (wr_done)       wr_bank  <= ~wr_bank;
        end
    end

    // Bank storage writes
    always_ff @(posedge clk) begin
        if (wr_store) mem[wr_bank][wr_idx[AW-1:0]] <= mfcc_in;
        if (wr_done)  last_idx[wr_bank] <= eff_last;
    end

    // Full flags: set by the writer, cleared by the reader (always different banks)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_done && wr_bank == 1'(b))      full[b] <= 1'b1;
                else if (rd_done && rd_bank == 1'(b)) full[b] <= 1'b0;
            end
        end
    end

    // Reader: present words back to back, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state   <= R_IDLE;
            rd_bank    <= 1'b0;
            feat_data  <= '0;
            feat_index <= 8'd0;
            feat_last  <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            if (rd_start) begin
                feat_data  <= mem[rd_bank][0];
                feat_index <= 8'd0;
                feat_last  <= (last_idx[rd_bank] == 8'd0);
            end else if (rd_xfer) begin
                if (feat_last) begin
                    rd_bank    <= ~rd_bank;
                    feat_index <= 8'd0;
                    feat_last  <= 1'b0;
                end else begin
                    feat_data  <= mem[rd_bank][next_idx[AW-1:0]];
                    feat_index <= next_idx;
                    feat_last  <= (next_idx == last_idx[rd_bank]);
                end
            end
        end
    end

    assign feat_valid = (rd_state == R_SEND);

    // Drop statistics; a drop on the same edge as a clear restarts the count at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_dropped <= 8'd0;
            overflow       <= 1'b0;
        end else if (drop_start) begin
            overflow <= 1'b1;
            if (clr_overflow)                 frames_dropped <= 8'd1;
            else if (frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
        end else if (clr_overflow) begin
            overflow       <= 1'b0;
            frames_dropped <= 8'd0;
        end
    end
endmodule
